// File: rtl/conv_layer_scheduler.sv
// Tile sequencer for one convolution layer: steps the shared conv-unit bank over
// every (filter, row, half-row) tile and issues one output-buffer write per tile.
module conv_layer_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int K          = 6,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              cu_reset,
  output logic [5:0]        row_number,
  output logic [5:0]        column,
  output logic [3:0]        filter_index,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int ROWS  = H - F + 1;
  localparam int UNITS = (W - F + 1) / 2;
  localparam int MACC  = D * F * F + 2;
  localparam int CNT_W = $clog2(MACC + 1);

  localparam logic [5:0]       UNITS_V   = 6'(UNITS);
  localparam logic [5:0]       LAST_ROW  = 6'(H - F);
  localparam logic [3:0]       LAST_FILT = 4'(K - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MACC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Reject configurations whose output map cannot be addressed.
  if ((2 ** ADDR_W) < (K * ROWS * 2) || DATA_WIDTH < 1) begin : g_cfg_check
    $error("conv_layer_scheduler: ADDR_W too small for K*(H-F+1)*2 tiles");
  end

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        row_q, row_d;
  logic [5:0]        col_q, col_d;
  logic [3:0]        filt_q, filt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cu_reset_q, cu_reset_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [3:0] f,
                                                  input logic [5:0] r,
                                                  input logic [5:0] c);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'(f) * ADDR_W'(ROWS) + ADDR_W'(r);
    return (base << 1) + ADDR_W'(c != 6'd0);
  endfunction

  // Tile sequencing: state, MAC window counter and select advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    filt_d  = filt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          row_d   = 6'd0;
          col_d   = 6'd0;
          filt_d  = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_WRITE: begin
        if (!out_ready) begin
          state_d = S_WRITE;
        end else if (col_q == 6'd0) begin
          col_d   = UNITS_V;
          state_d = S_CLEAR;
        end else if (row_q != LAST_ROW) begin
          col_d   = 6'd0;
          row_d   = row_q + 6'd1;
          state_d = S_CLEAR;
        end else if (filt_q != LAST_FILT) begin
          col_d   = 6'd0;
          row_d   = 6'd0;
          filt_d  = filt_q + 4'd1;
          state_d = S_CLEAR;
        end else begin
          // Last tile of the layer: selects keep their final values.
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;
      filt_d  = filt_q;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    wr_en_d    = (state_d == S_WRITE);
    cu_reset_d = 1'b1;
    case (state_d)
      S_COMPUTE: cu_reset_d = 1'b0;
      S_WRITE:   cu_reset_d = 1'b0;
      default:   cu_reset_d = 1'b1;
    endcase
    wr_addr_d = tile_addr(filt_d, row_d, col_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      row_q      <= 6'd0;
      col_q      <= 6'd0;
      filt_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cu_reset_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      filt_q     <= filt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cu_reset_q <= cu_reset_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cu_reset     = cu_reset_q;
  assign row_number   = row_q;
  assign column       = col_q;
  assign filter_index = filt_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: control-vector table plus whole-layer runs
// against a tile-index/elapsed-cycle reference model.
module tb_conv_layer_scheduler;
  localparam int H = 32, W = 32, F = 5, K = 6, D = 1, ADDR_W = 9;
  localparam int ROWS  = H - F + 1;
  localparam int UNITS = (W - F + 1) / 2;
  localparam int MACC  = D * F * F + 2;
  localparam int TILES = K * ROWS * 2;

  logic clk = 1'b0;
  logic reset, start, abort, out_ready;
  logic busy, done, cu_reset, wr_en;
  logic [5:0] row_number, column;
  logic [3:0] filter_index;
  logic [ADDR_W-1:0] wr_addr;

  int vectors = 0;
  int miscompares = 0;

  conv_layer_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy), .done(done), .cu_reset(cu_reset), .row_number(row_number),
    .column(column), .filter_index(filter_index), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, ab, rdy;
    bit e_busy, e_done, e_cu, e_wr;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs(input bit sel_v, input bit addr_v);
    return {3'b0, busy, done, cu_reset, wr_en,
            sel_v ? {row_number, column, filter_index} : 16'h0,
            addr_v ? wr_addr : 9'h0};
  endfunction

  // Expected value for tile j: selects and address follow from the tile index alone.
  function automatic logic [31:0] mk(input bit b, input bit d, input bit c, input bit w,
                                     input bit sel_v, input bit addr_v, input int j);
    logic [5:0] r, co;
    logic [3:0] f;
    logic [8:0] a;
    r  = 6'((j / 2) % ROWS);
    co = 6'((j % 2) * UNITS);
    f  = 4'(j / (2 * ROWS));
    a  = 9'(j);
    return {3'b0, b, d, c, w, sel_v ? {r, co, f} : 16'h0, addr_v ? a : 9'h0};
  endfunction

  // mode 0: always ready, 1: 10-cycle stall in third write, 2: random ready.
  task automatic run_layer(input int mode, input int abort_at, input int reset_at,
                           input int exp_done_n);
    int j, e, n, stall, done_n, done_cnt, bad, model_done_n;
    bit in_done, fin, ab, rdy, in_wr;
    logic [8:0] accq[$];
    j = 0; e = 1; n = 0; stall = 10; in_done = 0; fin = 0;
    done_n = 0; done_cnt = 0; bad = 0; model_done_n = 0;
    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (!fin && n < 12000) begin
      in_wr = (e >= MACC + 2);
      if (in_done) check("cyc_done", obs(1, 0), mk(1, 1, 1, 0, 1, 0, TILES - 1));
      else         check("cyc", obs(1, in_wr), mk(1, 0, e == 1, in_wr, 1, in_wr, j));
      if (done) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (mode == 0 && n == 29 * 56 + 1)
        check("wrap", 32'({row_number, column, filter_index}), 32'({6'd0, 6'd0, 4'd1}));
      if (reset_at != 0 && n == reset_at) begin
        reset = 1'b0;
        #2;
        check("async_rst", obs(1, 1), mk(0, 0, 1, 0, 1, 1, 0));
        tick;
        tick;
        reset = 1'b1;
        tick;
        check("post_rst", obs(1, 1), mk(0, 0, 1, 0, 1, 1, 0));
        return;
      end
      rdy = 1'b1;
      if (mode == 1 && j == 2 && in_wr && stall > 0) begin
        rdy = 1'b0;
        stall--;
      end
      if (mode == 2) rdy = ($urandom_range(0, 9) < 7);
      ab = (abort_at != 0 && n == abort_at);
      start = (!in_done && e >= 2 && e <= MACC + 1 && $urandom_range(0, 3) == 0);
      out_ready = rdy;
      abort = ab;
      if (wr_en && rdy && !ab) accq.push_back(wr_addr);
      if (ab || in_done) begin
        fin = 1;
      end else if (in_wr && rdy) begin
        if (j == TILES - 1) begin
          in_done = 1;
          model_done_n = n + 1;
        end else begin
          j++;
          e = 1;
        end
      end else begin
        e++;
      end
      tick;
      n++;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    check("finished", 32'(fin), 32'd1);
    check("idle", obs(0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    if (abort_at == 0) begin
      check("done_n", done_n, (exp_done_n > 0) ? exp_done_n : model_done_n);
      check("done_len", done_cnt, 1);
      check("nwrites", accq.size(), TILES);
      foreach (accq[i]) if (accq[i] != 9'(i)) bad++;
      check("addr_order", bad, 0);
    end else begin
      check("no_done", done_cnt, 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      check("idle_hold", obs(0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vals", obs(1, 1), mk(0, 0, 1, 0, 1, 1, 0));
    reset = 1'b1;
    repeat (20) tick;
    check("idle20", obs(1, 1), mk(0, 0, 1, 0, 1, 1, 0));

    // {start, abort, out_ready} applied at the next edge -> {busy, done, cu_reset, wr_en}
    repeat (3) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    repeat (MACC) tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    foreach (tbl[i]) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      out_ready = tbl[i].rdy;
      tick;
      check($sformatf("tbl%0d", i), 32'({busy, done, cu_reset, wr_en}),
            32'({tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cu, tbl[i].e_wr}));
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    tick;

    run_layer(0, 160, 0, 0);
    run_layer(0, 0, 0, 9745);
    run_layer(1, 0, 0, 9755);
    run_layer(2, 0, 0, 0);
    run_layer(0, 0, 116, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences one convolution layer over the shared bank of (W-F+1)/2 convolution units and the receptive-field selector.
- Per tile, it drives the row/column select and resets the conv units. It then waits out the multiply-accumulate window and issues one buffered write of the unit results.
- It iterates over K filters so a single unit bank serves every output map. Sits between the layer-level start/done control and the conv datapath/output buffer.

Parameters:
- DATA_WIDTH, 16, result word width (datapath only; scheduler passes no data)
- D, 1, filter depth
- H, 32, input height
- W, 32, input width
- F, 5, filter size
- K, 6, number of filters (output maps)
- ADDR_W, 9, output buffer address width; must satisfy 2^ADDR_W >= K*(H-F+1)*2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin layer; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE, no done
- out_ready  in  1  output buffer accepts write this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the layer completes
- cu_reset  out  1  reset to conv units, active-high
- row_number  out  6  output row being computed, 0..H-F
- column  out  6  tile column offset: 0 or (W-F+1)/2
- filter_index  out  4  filter bank select, 0..K-1
- wr_en  out  1  output buffer write request
- wr_addr  out  ADDR_W  output buffer address

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, cu_reset=1, row_number=0, column=0, filter_index=0, wr_en=0, wr_addr=0, cycle counter=0.
- UNITS=(W-F+1)/2; MACC=D*F*F+2 (27 at defaults). Tile sequence: CLEAR, COMPUTE, WRITE.
- IDLE:
  - cu_reset=1.
  - start=1 → CLEAR, with row_number/column/filter_index cleared to 0.
- CLEAR (1 cycle): cu_reset=1, counter←0 → COMPUTE.
- COMPUTE:
  - cu_reset=0; counter increments each cycle.
  - Stays exactly MACC cycles; on counter==MACC-1 → WRITE.
  - Selects stay stable throughout.
- WRITE:
  - cu_reset=0; wr_en=1; wr_addr=(filter_index*(H-F+1)+row_number)*2+(column!=0).
  - out_ready=0: hold WRITE; wr_en and wr_addr stable; conv results must stay valid, so cu_reset stays low.
  - out_ready=1: write accepted and selects advance at the same edge:
    - column==0 → column=UNITS.
    - Otherwise column=0 and row_number+1.
    - If that row was H-F: row_number=0, filter_index+1.
    - If that filter was K-1: → DONE, with selects left at final values.
    - Otherwise → CLEAR.
- DONE (1 cycle): done=1, busy=1 → IDLE.
- start while busy is ignored; start held high in IDLE after DONE starts a new layer.
- abort=1 in any non-IDLE state → IDLE at next edge: wr_en=0, cu_reset=1, no done. abort has priority over out_ready.
- Reset mid-operation: immediate return to reset values; no partial done.
- Unstalled timing:
  - Tile period = MACC+2 = 29 cycles.
  - Tiles = K*(H-F+1)*2 = 336.
  - Start sampled at edge t0 → done high in cycle t0+336*29+1 = t0+9745.
- Exactly one wr_en-with-out_ready handshake per tile. Addresses 0..335 each written once, in increasing order.

Test Plan:
- Reset then idle: reset low 3 cycles, release, start=0 for 20 cycles → busy=0, cu_reset=1, wr_en=0, all selects 0.
- Nominal layer, out_ready=1: single start pulse →
  - first wr_en 29 cycles after start, with wr_addr=0, row 0, column 0, filter 0;
  - second write has wr_addr=1, column=14;
  - 336 writes, addresses 0..335 strictly increasing;
  - done pulse exactly 9745 cycles after start, lasting 1 cycle.
- Backpressure: out_ready=0 for 10 cycles during the third WRITE → wr_en and wr_addr=2 held and cu_reset=0 throughout; total time +10 cycles; no lost or duplicate addresses.
- Boundary wrap: at row_number=27, column=14, filter 0, write accepted → next tile row 0, column 0, filter_index=1, wr_addr=56.
- Abort and restart: abort during COMPUTE of tile 5 → IDLE next cycle, no done, cu_reset=1. Start again → writes restart at wr_addr=0.
- Async reset mid-layer, plus start while busy: reset low during WRITE → outputs reach reset values without a clock edge. Separately, start pulses during COMPUTE cause no change to sequence or timing.
